// File: rtl/frame_byte_writer_pkg.sv
// Shared types and constants for the frame byte writer.
package frame_byte_writer_pkg;

    typedef enum logic [2:0] {IDLE, RUN, W0, W1, W2, DONE} state_t;

    localparam logic MODE_REPL = 1'b0;
    localparam logic MODE_PASS = 1'b1;

    localparam int DEF_WIDTH   = 128;
    localparam int DEF_HEIGHT  = 128;
    localparam int FRAME_BYTES = DEF_WIDTH * DEF_HEIGHT * 3;

    function automatic int frame_bytes(input int w, input int h);
        return w * h * 3;
    endfunction

endpackage

// File: rtl/frame_byte_writer_pos.sv
// Column/row position of the current pixel, with end-of-line and end-of-frame flags.
module pixel_pos_counter #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last_col,
    output logic last_pix
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign last_col = (col == CW'(WIDTH - 1));
    assign last_pix = last_col && (row == RW'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_byte_writer.sv
// Takes result bytes over valid/ready and writes them as an interleaved R,G,B frame
// into a byte-wide RAM, replicating one byte per pixel or passing three through.
module frame_byte_writer
    import frame_byte_writer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = $clog2(FRAME_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              line_end,
    output logic              done,
    output logic              busy
);

    localparam int FRAME = frame_bytes(WIDTH, HEIGHT);

    state_t     state, state_nx;
    logic       frame_mode;
    logic [1:0] sub;
    logic       last_col, last_pix;
    logic       take, pix_done, clr, le_nx;

    // in_ready is only ever high in RUN, so it doubles as the state qualifier
    assign take     = in_valid && in_ready;
    assign pix_done = (state == W2) ||
                      (state == W0 && frame_mode == MODE_PASS && sub == 2'd2);
    assign clr      = (state == IDLE) && start && !abort;

    pixel_pos_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .inc      (pix_done),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    always_comb begin
        state_nx = state;
        le_nx    = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                if (take) begin
                    state_nx = W0;
                    le_nx    = (frame_mode == MODE_PASS) && (sub == 2'd2) && last_col;
                end
            end
            W0: begin
                if (frame_mode == MODE_REPL) state_nx = W1;
                else                         state_nx = (pix_done && last_pix) ? DONE : RUN;
            end
            W1: begin
                state_nx = W2;
                le_nx    = last_col;
            end
            W2:      state_nx = last_pix ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            le_nx    = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_mode <= MODE_REPL;
            sub        <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            line_end   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == RUN);
            mem_we   <= (state_nx == W0) || (state_nx == W1) || (state_nx == W2);
            line_end <= le_nx;
            done     <= (state_nx == DONE);
            busy     <= (state_nx != IDLE);
            if (clr) begin
                frame_mode <= mode;
                sub        <= '0;
                mem_addr   <= '0;
            end else if (mem_we) begin
                if (mem_addr != ADDR_W'(FRAME - 1)) mem_addr <= mem_addr + 1'b1;
                if (frame_mode == MODE_PASS) sub <= (sub == 2'd2) ? 2'd0 : sub + 2'd1;
            end
            if (take) mem_wdata <= in_data;
        end
    end

endmodule

// File: tb/tb_frame_byte_writer.sv
// Scoreboard bench: small 4x2 frames for protocol corners, one full-size replicate frame.
module tb_frame_byte_writer;
    import frame_byte_writer_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 16;
    localparam int NB = W * H * 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, mode, in_valid;
    logic [7:0] in_data, mem_wdata;
    logic in_ready, mem_we, line_end, done, busy;
    logic [AW-1:0] mem_addr;

    frame_byte_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .line_end(line_end), .done(done), .busy(busy)
    );

    logic f_start, f_abort, f_mode, f_valid;
    logic [7:0] f_data, f_wdata;
    logic f_ready, f_we, f_le, f_done, f_busy;
    logic [15:0] f_addr;

    frame_byte_writer u_full (
        .clk(clk), .rst(rst), .start(f_start), .abort(f_abort), .mode(f_mode),
        .in_valid(f_valid), .in_data(f_data), .in_ready(f_ready),
        .mem_we(f_we), .mem_addr(f_addr), .mem_wdata(f_wdata),
        .line_end(f_le), .done(f_done), .busy(f_busy)
    );

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- small-frame scoreboard ----------------
    typedef struct { int cyc; int addr; int data; bit le; } wr_t;
    wr_t q[$];
    wr_t e;
    int  m_addr, m_pix, m_sub, last_acc = -1, exp_done = -1;
    bit  m_mode, m_active = 0, gap_chk = 0, prev_done = 0;
    int  n_wr = 0, n_le = 0, n_done = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            n_wr++;
            if (q.size() == 0) chk("spurious_we", 1, 0);
            else begin
                e = q.pop_front();
                chk("wr_cyc", cyc, e.cyc);
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wr_le", line_end, e.le);
                if (e.addr == NB - 1) exp_done = cyc + 1;
            end
        end else if (line_end) chk("le_no_we", 1, 0);
        if (line_end) n_le++;
        if (prev_done) chk("busy_after_done", busy, 0);
        prev_done = done;
        if (in_ready)
            chk("ready_early", m_active && (last_acc < 0 || cyc - last_acc > (m_mode ? 1 : 3)), 1);
        if (rst || abort) begin
            q.delete();
            m_active = 0;
            exp_done = -1;
        end else if (start && !m_active) begin
            m_active = 1; m_mode = mode; m_addr = 0; m_pix = 0; m_sub = 0; last_acc = -1;
        end else if (in_valid && in_ready) begin
            if (gap_chk && last_acc >= 0) chk("acc_gap", cyc - last_acc, m_mode ? 2 : 4);
            last_acc = cyc;
            if (m_mode == MODE_REPL) begin
                for (int k = 0; k < 3; k++)
                    q.push_back('{cyc + 1 + k, m_addr + k, int'(in_data), (k == 2) && (m_pix % W == W - 1)});
                m_addr += 3;
                m_pix++;
            end else begin
                q.push_back('{cyc + 1, m_addr, int'(in_data), (m_sub == 2) && (m_pix % W == W - 1)});
                m_addr++;
                if (m_sub == 2) begin m_sub = 0; m_pix++; end
                else m_sub++;
            end
        end
        if (done) begin
            n_done++;
            chk("done_cyc", cyc, exp_done);
            exp_done = -1;
            m_active = 0;
        end
    end

    // ---------------- full-frame monitor ----------------
    logic [7:0] f_q[$];
    int f_wr = 0, f_rep = 0, f_le_n = 0, f_done_n = 0, f_last = -1;

    always @(negedge clk) begin
        if (f_valid && f_ready) f_q.push_back(f_data);
        if (f_we) begin
            chk("f_addr", f_addr, f_wr);
            chk("f_le", f_le, (f_wr % (DEF_WIDTH * 3)) == DEF_WIDTH * 3 - 1);
            if (f_q.size() == 0) chk("f_underrun", 1, 0);
            else begin
                chk("f_data", f_wdata, f_q[0]);
                if (f_rep == 2) begin void'(f_q.pop_front()); f_rep = 0; end
                else f_rep++;
            end
            f_last = int'(f_addr);
            f_wr++;
        end
        if (f_le) f_le_n++;
        if (f_done) f_done_n++;
    end

    // ---------------- stimulus ----------------
    task automatic outs_zero();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_line_end", line_end, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic start_frame(input bit md);
        @(posedge clk); #1;
        start = 1; mode = md;
        @(posedge clk); #1;
        start = 0;
    endtask

    // vmode 0: valid held, sequential data; 1: random valid gaps; 2: valid held, data changes every cycle
    task automatic feed(input int vmode, input logic [7:0] base, input int nacc, input bit spam);
        int idx = 0, guard = 0;
        bit acc;
        in_data  = (vmode == 2) ? 8'($urandom) : base;
        in_valid = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (idx < nacc && guard < 500) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) idx++;
            in_data  = (vmode == 2) ? 8'($urandom) : base + 8'(idx);
            in_valid = (idx < nacc) && ((vmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1);
            start    = spam && (guard % 7 == 3);
        end
        chk("feed_timeout", guard < 500, 1);
        in_valid = 0;
        start    = 0;
    endtask

    task automatic wait_done(input int prev);
        int g = 0;
        while (n_done == prev && g < 300) begin @(posedge clk); g++; end
        chk("done_seen", n_done, prev + 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame_test(input bit md, input int vmode, input logic [7:0] base, input bit spam);
        int w0 = n_wr, l0 = n_le, d0 = n_done;
        gap_chk = (vmode != 1);
        start_frame(md);
        feed(vmode, base, md ? NB : W * H, spam);
        wait_done(d0);
        chk("frame_writes", n_wr - w0, NB);
        chk("frame_line_ends", n_le - l0, H);
        chk("frame_q_empty", q.size(), 0);
        chk("frame_idle", busy, 0);
    endtask

    initial begin
        int w0, d0, g;
        rst = 1; start = 0; abort = 0; mode = 0; in_valid = 0; in_data = 0;
        f_start = 0; f_abort = 0; f_mode = 0; f_valid = 0; f_data = 0;
        repeat (3) @(posedge clk);
        #1;
        outs_zero();
        @(posedge clk); #1;
        rst = 0;

        frame_test(MODE_REPL, 0, 8'h10, 0);
        frame_test(MODE_PASS, 1, 8'h00, 0);
        frame_test(MODE_REPL, 2, 8'h00, 0);

        // abort partway into the sixth pixel, with a start in the same cycle
        w0 = n_wr; d0 = n_done;
        gap_chk = 1;
        start_frame(MODE_REPL);
        feed(0, 8'h40, 6, 0);
        abort = 1; start = 1;
        @(posedge clk); #1;
        abort = 0; start = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_we", mem_we, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_writes", n_wr - w0, 16);
        chk("abort_no_done", n_done, d0);
        // abort beats start in IDLE
        start = 1; abort = 1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        @(negedge clk);
        chk("abort_over_start", busy, 0);
        frame_test(MODE_PASS, 0, 8'h80, 0);

        // reset during W1
        start_frame(MODE_REPL);
        feed(0, 8'h60, 1, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        outs_zero();
        frame_test(MODE_REPL, 0, 8'h70, 1);

        // full-size replicate frame
        @(posedge clk); #1;
        f_start = 1; f_mode = MODE_REPL;
        @(posedge clk); #1;
        f_start = 0; f_valid = 1; f_data = 8'($urandom);
        g = 0;
        while (f_done_n == 0 && g < 70000) begin
            @(posedge clk); #1;
            f_data = 8'($urandom);
            g++;
        end
        f_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("full_writes", f_wr, FRAME_BYTES);
        chk("full_last_addr", f_last, FRAME_BYTES - 1);
        chk("full_line_ends", f_le_n, DEF_HEIGHT);
        chk("full_done", f_done_n, 1);
        chk("full_busy", f_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
